config_loader: RTL

CONFIG_LOADER -- requirements
Module: config_loader

---
 rtl/config_loader_pkg.sv | 22 ++
 rtl/cfg_shadow_reg.sv | 32 +++
 rtl/config_loader.sv | 105 ++++++++++
 3 files changed

// File: rtl/config_loader_pkg.sv
// Shared types and constants for the configuration stream loader.
// Holds the loader FSM encoding, checksum width and word-count helpers.
package config_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int CSUM_W = 8;

  function automatic int calc_nwords(input int bits, input int w);
    return (bits + w - 1) / w;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cfg_shadow_reg.sv
// Word-indexed shadow register that collects an image before it is committed.
// Bits beyond CFG_BITS in the final word are dropped rather than stored.
module cfg_shadow_reg
  import config_loader_pkg::*;
#(
  parameter int CFG_BITS = 72,
  parameter int W        = 8,
  parameter int NWORDS   = calc_nwords(CFG_BITS, W),
  parameter int IDX_W    = idx_width(NWORDS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                we,
  input  logic [IDX_W-1:0]    idx,
  input  logic [W-1:0]        wdata,
  output logic [CFG_BITS-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (we) begin
      for (int i = 0; i < CFG_BITS; i++) begin
        if (idx == IDX_W'(i / W)) q[i] <= wdata[i % W];
      end
    end
  end

endmodule

// File: rtl/config_loader.sv
// Loads a checksummed configuration image from a word stream and commits it
// atomically to c; a failed checksum leaves c untouched and raises error.
module config_loader
  import config_loader_pkg::*;
#(
  parameter int CFG_BITS = 72,
  parameter int W        = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [W-1:0]        data_in,
  input  logic                data_valid,
  output logic                data_ready,
  output logic [CFG_BITS-1:0] c,
  output logic                cfg_valid,
  output logic                busy,
  output logic                error
);

  localparam int NWORDS = calc_nwords(CFG_BITS, W);
  localparam int IDX_W  = idx_width(NWORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    cnt;
  logic [CSUM_W-1:0]   sum;
  logic [CFG_BITS-1:0] shadow;
  logic                xfer, word_we, csum_xfer, csum_ok;

  assign xfer      = data_valid && data_ready;
  // A start in the same cycle as a transfer wins: the word is dropped.
  assign word_we   = (state == LOAD)  && xfer && !start;
  assign csum_xfer = (state == CHECK) && xfer && !start;
  assign csum_ok   = (data_in[CSUM_W-1:0] == sum);

  cfg_shadow_reg #(
    .CFG_BITS (CFG_BITS),
    .W        (W),
    .NWORDS   (NWORDS),
    .IDX_W    (IDX_W)
  ) u_shadow (
    .clk   (clk),
    .rst   (rst),
    .clr   (start),
    .we    (word_we),
    .idx   (cnt),
    .wdata (data_in),
    .q     (shadow)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = LOAD;
      LOAD: begin
        if (start)                           state_nxt = LOAD;
        else if (xfer && (cnt == LAST_IDX))  state_nxt = CHECK;
      end
      CHECK: begin
        if (start)     state_nxt = LOAD;
        else if (xfer) state_nxt = csum_ok ? DONE : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    data_ready = (state == LOAD) || (state == CHECK);
    busy       = data_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      sum       <= '0;
      c         <= '0;
      cfg_valid <= 1'b0;
      error     <= 1'b0;
    end else if (start) begin
      cnt   <= '0;
      sum   <= '0;
      error <= 1'b0;
    end else if (word_we) begin
      cnt <= cnt + 1'b1;
      // The sum covers the full word, including bits the shadow discards.
      sum <= sum + CSUM_W'(data_in);
    end else if (csum_xfer) begin
      if (csum_ok) begin
        c         <= shadow;
        cfg_valid <= 1'b1;
        error     <= 1'b0;
      end else begin
        cfg_valid <= 1'b0;
        error     <= 1'b1;
      end
    end
  end

endmodule
